// File: rtl/crc_pkg.sv
// Shared constants and FSM encoding for the CRC16 framing arbiter.
package crc_pkg;

  localparam logic [15:0] CRC_INIT_DEF = 16'hFFFF;
  localparam logic [15:0] CRC_POLY_DEF = 16'h1021;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    CRC_HI = 2'd2,
    CRC_LO = 2'd3
  } arb_state_e;

endpackage

// File: rtl/crc16_byte_step.sv
// One byte of CRC16 update: 8 MSB-first shift steps, no reflection, no final XOR.
module crc16_byte_step
  import crc_pkg::*;
#(
  parameter logic [15:0] POLY = CRC_POLY_DEF
) (
  input  logic [15:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      c = {c[14:0], 1'b0} ^ (((c[15] ^ data_in[i]) == 1'b1) ? POLY : 16'h0000);
    end
    crc_out = c;
  end

endmodule

// File: rtl/crc16_frame_arb.sv
// Two-requester round-robin frame arbiter that appends a CRC16 (hi, lo) to each frame.
// Handshake: a byte moves when valid & ready are both high at a rising clk edge;
// valid never waits on ready, and a stalled beat holds its payload until taken.
module crc16_frame_arb
  import crc_pkg::*;
#(
  parameter logic [15:0] CRC_INIT = CRC_INIT_DEF,
  parameter logic [15:0] CRC_POLY = CRC_POLY_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s0_valid,
  input  logic [7:0]  s0_data,
  input  logic        s0_last,
  output logic        s0_ready,
  input  logic        s1_valid,
  input  logic [7:0]  s1_data,
  input  logic        s1_last,
  output logic        s1_ready,
  output logic        m_valid,
  output logic [7:0]  m_data,
  output logic        m_last,
  output logic        m_src,
  input  logic        m_ready,
  output logic        busy,
  output logic [15:0] frames0,
  output logic [15:0] frames1,
  output logic [1:0]  state_dbg
);

  arb_state_e  state_q, state_d;
  logic        grant_q, grant_d;
  logic        rr_q, rr_d;
  logic [15:0] crc_q, crc_d;
  logic [15:0] crc_next;
  logic [15:0] frames0_q, frames1_q;
  logic        inc0, inc1;

  logic        sel_valid;
  logic [7:0]  sel_data;
  logic        sel_last;

  assign sel_valid = grant_q ? s1_valid : s0_valid;
  assign sel_data  = grant_q ? s1_data  : s0_data;
  assign sel_last  = grant_q ? s1_last  : s0_last;

  crc16_byte_step #(.POLY(CRC_POLY)) u_step (
    .crc_in  (crc_q),
    .data_in (sel_data),
    .crc_out (crc_next)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    crc_d    = crc_q;
    inc0     = 1'b0;
    inc1     = 1'b0;
    s0_ready = 1'b0;
    s1_ready = 1'b0;
    m_valid  = 1'b0;
    m_data   = 8'h00;
    m_last   = 1'b0;
    m_src    = 1'b0;
    case (state_q)
      IDLE: begin
        // Arbitration cycle only: nothing is accepted here.
        if (s0_valid || s1_valid) begin
          grant_d = (s0_valid && s1_valid) ? rr_q : s1_valid;
          crc_d   = CRC_INIT;
          state_d = DATA;
        end
      end
      DATA: begin
        m_valid  = sel_valid;
        m_data   = sel_data;
        m_src    = grant_q;
        s0_ready = !grant_q && m_ready;
        s1_ready = grant_q && m_ready;
        if (sel_valid && m_ready) begin
          crc_d = crc_next;
          if (sel_last) state_d = CRC_HI;
        end
      end
      CRC_HI: begin
        m_valid = 1'b1;
        m_data  = crc_q[15:8];
        m_src   = grant_q;
        if (m_ready) state_d = CRC_LO;
      end
      CRC_LO: begin
        m_valid = 1'b1;
        m_data  = crc_q[7:0];
        m_last  = 1'b1;
        m_src   = grant_q;
        if (m_ready) begin
          state_d = IDLE;
          rr_d    = !grant_q;
          inc0    = !grant_q;
          inc1    = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      rr_q      <= 1'b0;
      crc_q     <= CRC_INIT;
      frames0_q <= 16'h0000;
      frames1_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      crc_q   <= crc_d;
      if (inc0) frames0_q <= frames0_q + 16'd1;
      if (inc1) frames1_q <= frames1_q + 16'd1;
    end
  end

  assign busy      = (state_q != IDLE);
  assign frames0   = frames0_q;
  assign frames1   = frames1_q;
  assign state_dbg = state_q;

endmodule
